stream_arb_mux: RTL

- Parametrised N-channel, W-bit multiplexer with a valid/ready handshake on every input and on the output.
- Selects one input per transfer, either by round-robin arbitration or by a fixed address. The fixed-address mode is the same behaviour as the 4:1 address mux, generalised to N channels.
- The output stage is a single registered slot.
- Sits between producer blocks and a shared consumer, such as a register-file write port or ALU operand bus.

---
 rtl/stream_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 58 +++++
 rtl/stream_arb_mux.sv | 100 ++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared constants and helpers for the stream arbitration mux and its arbiter.
package stream_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  localparam int CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: round-robin search from a pointer, or a
// fixed address that is granted only when that channel is requesting.
module rr_arbiter
  import stream_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  input  logic              i_mode,
  input  logic [CH_W-1:0]   i_addr,
  output logic [CH_W-1:0]   o_grant,
  output logic              o_grant_valid
);

  localparam int            PAD_W    = 1 << CH_W;
  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  // Zero-padded to the full index range so an out-of-range address reads 0.
  logic [PAD_W-1:0] w_req_pad;
  logic [CH_W:0]    w_idx;
  logic [CH_W-1:0]  w_rr_grant;
  logic             w_rr_valid;

  assign w_req_pad = PAD_W'(i_req);

  // Walk offsets from the far end so the closest requester to i_ptr wins last.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    w_rr_grant = '0;
    w_rr_valid = 1'b0;
    w_idx      = '0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      w_idx = {1'b0, i_ptr} + (CH_W + 1)'(off);
      if (w_idx >= NUM_CH_L) w_idx = w_idx - NUM_CH_L;
      if (w_req_pad[w_idx[CH_W-1:0]]) begin
        w_rr_grant = w_idx[CH_W-1:0];
        w_rr_valid = 1'b1;
      end
    end
  end

  always_comb begin
    o_grant       = '0;
    o_grant_valid = 1'b0;
    if (i_mode == MODE_FIXED) begin
      if (w_req_pad[i_addr]) begin
        o_grant       = i_addr;
        o_grant_valid = 1'b1;
      end
    end else begin
      o_grant       = w_rr_grant;
      o_grant_valid = w_rr_valid;
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-channel valid/ready mux with round-robin or fixed-address selection into a
// single registered output slot. Optional counters: STREAM_ARB_MUX_COUNT_EN.
module stream_arb_mux
  import stream_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode,
  input  logic [CH_W-1:0]          address,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef STREAM_ARB_MUX_COUNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]  beat_count,
  output logic [CNT_W-1:0]         stall_count
`endif
);

  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   w_grant;
  logic              w_grant_valid;
  logic              w_load;
  logic              w_xfer;
  logic [DATA_W-1:0] w_sel_data;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_req         (in_valid),
    .i_ptr         (r_rr_ptr),
    .i_mode        (mode),
    .i_addr        (address),
    .o_grant       (w_grant),
    .o_grant_valid (w_grant_valid)
  );

  // The slot can take a beat when empty or when its current beat leaves now.
  assign w_load = ~out_valid | out_ready;
  assign w_xfer = w_load & w_grant_valid & ~reset;

  always_comb begin
    in_ready   = '0;
    w_sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_grant == CH_W'(k)) begin
        in_ready[k] = w_xfer;
        w_sel_data  = in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments only.
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      r_rr_ptr  <= '0;
    end else if (w_load) begin
      out_valid <= w_grant_valid;
      if (w_grant_valid) begin
        out_data <= w_sel_data;
        out_ch   <= w_grant;
        // Explicit wrap: NUM_CH need not be a power of two.
        if (mode == MODE_RR)
          r_rr_ptr <= (w_grant == CH_W'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;
      end
    end
  end

`ifdef STREAM_ARB_MUX_COUNT_EN
  logic [CNT_W-1:0] r_beat_cnt [NUM_CH];
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the counter array is software-visible, so every entry is cleared on reset.
      for (int k = 0; k < NUM_CH; k++) r_beat_cnt[k] <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (in_valid[k] & in_ready[k]) r_beat_cnt[k] <= sat_inc(r_beat_cnt[k]);
      if (out_valid & ~out_ready) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_beat
    assign beat_count[k*CNT_W +: CNT_W] = r_beat_cnt[k];
  end
  assign stall_count = r_stall_cnt;
`endif

endmodule
